// File: rtl/wrc_tag_poller.sv
// Wishbone master that arms the WR core tagger, polls CTRL and drains
// captured tags into a small FIFO with a valid/ready consumer port.
module wrc_tag_poller #(
    parameter logic [17:0] g_base_addr       = 18'h40000,
    parameter logic [31:0] g_init_value      = 32'h0000dead,
    parameter int          g_poll_interval   = 100,
    parameter int          g_ack_timeout     = 64,
    parameter int          g_fifo_depth_log2 = 3
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    output logic [31:0] tag_o,
    output logic        tag_valid_o,
    input  logic        tag_ready_i,
    output logic        overflow_o,
    output logic        bus_err_o,
    input  logic        clr_i,
    output logic        busy_o,
    output logic [17:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_POLL   = 3'd4;
    localparam logic [2:0] S_RDTAG  = 3'd5;
    localparam logic [2:0] S_DISARM = 3'd6;

    localparam int c_aw    = g_fifo_depth_log2;
    localparam int c_depth = 1 << c_aw;
    localparam int c_pw    = $clog2(g_poll_interval + 1);
    localparam int c_tw    = $clog2(g_ack_timeout + 1);

    localparam logic [c_pw-1:0] c_poll_last = c_pw'(g_poll_interval - 1);
    localparam logic [c_tw-1:0] c_tmo_last  = c_tw'(g_ack_timeout - 1);
    localparam logic [c_aw:0]   c_full_cnt  = (c_aw + 1)'(c_depth);

    localparam logic [17:0] c_adr_ctrl = g_base_addr;
    localparam logic [17:0] c_adr_tag  = g_base_addr + 18'h4;
    localparam logic [17:0] c_adr_init = g_base_addr + 18'h10;

    logic [2:0]      r_state;
    logic [c_pw-1:0] r_wait_cnt;
    logic [c_tw-1:0] r_tmo_cnt;
    logic            r_cyc;
    logic            r_we;
    logic [17:0]     r_adr;
    logic [31:0]     r_dat;
    logic            r_ovf;
    logic            r_err;

    logic [31:0]     r_mem [c_depth];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;

    logic        w_bus_st;
    logic        w_ack;
    logic        w_tmo;
    logic        w_full;
    logic        w_empty;
    logic        w_wait_done;
    logic        w_poll_go;
    logic        w_set_ovf;
    logic        w_launch;
    logic        w_pop;
    logic        w_push;
    logic [17:0] w_l_adr;
    logic        w_l_we;
    logic [31:0] w_l_dat;
    logic [2:0]  w_ack_nxt;

    assign w_bus_st = (r_state == S_ARM)   | (r_state == S_LOAD) |
                      (r_state == S_POLL)  | (r_state == S_RDTAG) |
                      (r_state == S_DISARM);

    assign w_ack   = r_cyc & wb_ack_i;
    assign w_tmo   = r_cyc & ~wb_ack_i & (r_tmo_cnt == c_tmo_last);
    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);

    assign w_wait_done = (r_state == S_WAIT) & enable_i &
                         (r_wait_cnt == c_poll_last);
    assign w_poll_go   = w_wait_done & ~w_full;
    assign w_set_ovf   = w_wait_done & w_full;

    // The WAIT->POLL edge launches the read itself so the poll strobe
    // lands exactly g_poll_interval cycles after WAIT entry.
    assign w_launch = (w_bus_st & ~r_cyc) | w_poll_go;

    assign w_pop  = ~w_empty & tag_ready_i;
    assign w_push = (r_state == S_RDTAG) & w_ack & (~w_full | w_pop);

    always_comb begin
        w_l_adr = c_adr_ctrl;
        w_l_we  = 1'b0;
        w_l_dat = '0;
        case (r_state)
            S_ARM: begin
                w_l_we  = 1'b1;
                w_l_dat = 32'h1;
            end
            S_LOAD: begin
                w_l_adr = c_adr_init;
                w_l_we  = 1'b1;
                w_l_dat = g_init_value;
            end
            S_RDTAG:  w_l_adr = c_adr_tag;
            S_DISARM: w_l_we  = 1'b1;
            default:  w_l_adr = c_adr_ctrl;
        endcase
    end

    always_comb begin
        w_ack_nxt = S_IDLE;
        case (r_state)
            S_ARM:   w_ack_nxt = enable_i ? S_LOAD : S_DISARM;
            S_LOAD:  w_ack_nxt = enable_i ? S_WAIT : S_DISARM;
            S_POLL: begin
                if (!enable_i)
                    w_ack_nxt = S_DISARM;
                else if (wb_dat_i[3])
                    w_ack_nxt = S_RDTAG;
                else
                    w_ack_nxt = S_WAIT;
            end
            S_RDTAG: w_ack_nxt = enable_i ? S_WAIT : S_DISARM;
            default: w_ack_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i)
                        r_state <= S_ARM;
                end
                S_WAIT: begin
                    if (!enable_i)
                        r_state <= S_DISARM;
                    else if (w_poll_go)
                        r_state <= S_POLL;
                end
                S_ARM, S_LOAD, S_POLL, S_RDTAG, S_DISARM: begin
                    if (w_ack)
                        r_state <= w_ack_nxt;
                    else if (w_tmo)
                        r_state <= enable_i ? S_WAIT : S_DISARM;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_wait_cnt <= '0;
        else if ((r_state != S_WAIT) || w_wait_done)
            r_wait_cnt <= '0;
        else
            r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_tmo_cnt <= '0;
        end else if (w_launch) begin
            r_cyc     <= 1'b1;
            r_we      <= w_l_we;
            r_adr     <= w_l_adr;
            r_dat     <= w_l_dat;
            r_tmo_cnt <= '0;
        end else if (w_ack || w_tmo) begin
            r_cyc     <= 1'b0;
            r_tmo_cnt <= '0;
        end else if (r_cyc) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Clear wins over a same-cycle set on both sticky flags.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else if (clr_i) begin
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_set_ovf)
                r_ovf <= 1'b1;
            if (w_tmo)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < c_depth; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wb_dat_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign tag_o       = r_mem[r_rd_ptr];
    assign tag_valid_o = ~w_empty;
    assign overflow_o  = r_ovf;
    assign bus_err_o   = r_err;
    assign busy_o      = (r_state != S_IDLE);

    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;

endmodule

// File: tb/tb_wrc_tag_poller.sv
// Directed bench for wrc_tag_poller: a behavioural Wishbone slave logs
// every transaction and the stimulus checks sequencing, timing and FIFO.
module tb_wrc_tag_poller;

    localparam logic [17:0] A_CTRL = 18'h40000;
    localparam logic [17:0] A_TAG  = 18'h40004;
    localparam logic [17:0] A_INIT = 18'h40010;

    typedef struct packed {
        logic [17:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [31:0] t_stb;
        logic [31:0] t_end;
        logic        acked;
    } txn_t;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] tag;
    logic        tag_valid;
    logic        tag_ready = 1'b0;
    logic        overflow;
    logic        bus_err;
    logic        clr = 1'b0;
    logic        busy;
    logic [17:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned cyc_n = 0;

    txn_t        log_q[$];
    txn_t        s_e;
    logic        s_in = 1'b0;
    int unsigned s_t0 = 0;
    int unsigned s_w = 0;
    int unsigned s_delay = 0;
    logic        s_noack = 1'b0;
    logic [31:0] s_ctrl = '0;
    logic [31:0] s_tag = '0;

    wrc_tag_poller dut (
        .clk_sys_i   (clk_sys),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .tag_o       (tag),
        .tag_valid_o (tag_valid),
        .tag_ready_i (tag_ready),
        .overflow_o  (overflow),
        .bus_err_o   (bus_err),
        .clr_i       (clr),
        .busy_o      (busy),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_ack_i    (wb_ack_i)
    );

    initial forever #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc_n++;

    // t_stb: edge that raised stb; t_end: edge of the ack or of the drop.
    always @(negedge clk_sys) begin
        if (wb_ack_i) begin
            wb_ack_i = 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            if (!s_in) begin
                s_in = 1'b1;
                s_t0 = cyc_n;
                s_w  = 0;
            end
            if (!s_noack && s_w >= s_delay) begin
                s_e.adr   = wb_adr_o;
                s_e.we    = wb_we_o;
                s_e.t_stb = s_t0;
                s_e.t_end = cyc_n + 1;
                s_e.acked = 1'b1;
                if (wb_we_o) begin
                    s_e.dat = wb_dat_o;
                end else if (wb_adr_o == A_TAG) begin
                    s_e.dat = s_tag;
                    s_tag++;
                end else if (wb_adr_o == A_CTRL) begin
                    s_e.dat = s_ctrl;
                end else begin
                    s_e.dat = '0;
                end
                if (!wb_we_o)
                    wb_dat_i = s_e.dat;
                wb_ack_i = 1'b1;
                log_q.push_back(s_e);
                s_in = 1'b0;
            end else begin
                s_w++;
            end
        end else if (s_in) begin
            s_e.adr   = wb_adr_o;
            s_e.we    = wb_we_o;
            s_e.dat   = '0;
            s_e.t_stb = s_t0;
            s_e.t_end = cyc_n;
            s_e.acked = 1'b0;
            log_q.push_back(s_e);
            s_in = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    function automatic txn_t ent(input int idx);
        txn_t t;
        t = '0;
        if (idx < log_q.size())
            t = log_q[idx];
        return t;
    endfunction

    function automatic int n_tag_reads(input int from);
        int n;
        n = 0;
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].acked && !log_q[i].we && log_q[i].adr == A_TAG)
                n++;
        return n;
    endfunction

    task automatic wait_log(input int n, input int budget, input string name);
        for (int i = 0; i < budget && log_q.size() < n; i++)
            tick();
        check(name, 32'(log_q.size() >= n), 32'd1);
    endtask

    initial begin
        int   base;
        int   nsz;
        txn_t e;

        // Reset values
        tick();
        tick();
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_adr", 32'(wb_adr_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'hF);
        check("rst_valid", 32'(tag_valid), 32'd0);
        check("rst_tag", tag, 32'd0);
        check("rst_flags", {30'd0, overflow, bus_err}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Arming sequence and poll interval
        enable = 1'b1;
        tick();
        check("busy_on", 32'(busy), 32'd1);
        wait_log(3, 400, "arm_seq_seen");
        e = ent(0);
        check("arm_adr", 32'(e.adr), 32'(A_CTRL));
        check("arm_dat", e.dat, 32'h1);
        check("arm_we", 32'(e.we), 32'd1);
        e = ent(1);
        check("load_adr", 32'(e.adr), 32'(A_INIT));
        check("load_dat", e.dat, 32'h0000dead);
        check("load_gap", ent(1).t_stb - ent(0).t_end, 32'd1);
        e = ent(2);
        check("poll_rd", {13'd0, e.adr, e.we}, {13'd0, A_CTRL, 1'b0});
        check("poll_interval", ent(2).t_stb - ent(1).t_end, 32'd100);

        // Single tag through the FIFO
        s_ctrl = 32'h8;
        s_tag  = 32'd42;
        base   = log_q.size();
        wait_log(base + 2, 300, "tag42_read");
        check("tag42_adr", 32'(ent(base + 1).adr), 32'(A_TAG));
        check("valid_before", 32'(tag_valid), 32'd0);
        tick();
        s_ctrl = 32'h0;
        check("valid_after", 32'(tag_valid), 32'd1);
        check("tag42", tag, 32'd42);
        tag_ready = 1'b1;
        tick();
        tag_ready = 1'b0;
        check("popped", 32'(tag_valid), 32'd0);

        // Fill to depth 8, then overflow
        s_ctrl = 32'h8;
        s_tag  = 32'd100;
        base   = log_q.size();
        for (int i = 0; i < 3000 && !overflow; i++)
            tick();
        check("ovf_set", 32'(overflow), 32'd1);
        check("tags_buffered", 32'(n_tag_reads(base)), 32'd8);
        nsz = log_q.size();
        for (int i = 0; i < 250; i++)
            tick();
        check("no_bus_when_full", 32'(log_q.size()), 32'(nsz));
        check("head100", tag, 32'd100);
        tag_ready = 1'b1;
        tick();
        tag_ready = 1'b0;
        check("head101", tag, 32'd101);
        base = log_q.size();
        wait_log(base + 2, 400, "tag108_read");
        check("tag108", ent(base + 1).dat, 32'd108);
        tag_ready = 1'b1;
        tick();
        tag_ready = 1'b0;
        s_ctrl = 32'h0;
        check("pushpop_head", tag, 32'd102);
        tag_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("drain", tag, 32'(102 + i));
            tick();
        end
        tag_ready = 1'b0;
        check("drained", 32'(tag_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Ack timeout on a poll
        s_noack = 1'b1;
        base = log_q.size();
        wait_log(base + 1, 300, "abort_seen");
        e = ent(base);
        check("abort_noack", 32'(e.acked), 32'd0);
        check("tmo_len", e.t_end - e.t_stb, 32'd64);
        check("bus_err_set", 32'(bus_err), 32'd1);
        s_noack = 1'b0;
        wait_log(base + 2, 300, "poll_resumed");
        check("resume_rd", {13'd0, ent(base + 1).adr, ent(base + 1).we},
              {13'd0, A_CTRL, 1'b0});
        check("resume_gap", ent(base + 1).t_stb - e.t_end, 32'd100);
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("bus_err_clr", 32'(bus_err), 32'd0);

        // Disable while a poll is pending
        s_delay = 5;
        for (int i = 0; i < 300 && !(wb_stb_o && !wb_we_o); i++)
            tick();
        check("poll_pending", 32'(wb_stb_o && !wb_we_o), 32'd1);
        base = log_q.size();
        enable = 1'b0;
        wait_log(base + 2, 100, "disarm_seen");
        check("poll_done", {14'd0, ent(base).adr, ent(base).we,
              ent(base).acked}, {14'd0, A_CTRL, 1'b0, 1'b1});
        check("disarm_adr", 32'(ent(base + 1).adr), 32'(A_CTRL));
        check("disarm_dat", {31'd0, ~ent(base + 1).we} | ent(base + 1).dat,
              32'd0);
        check("busy_at_ack", 32'(busy), 32'd1);
        tick();
        check("idle_after", 32'(busy), 32'd0);

        // Asynchronous reset during RDTAG
        s_delay = 10;
        s_ctrl  = 32'h8;
        s_tag   = 32'd500;
        base    = log_q.size();
        enable  = 1'b1;
        wait_log(base + 4, 600, "rst_tag1");
        check("rst_tag1_dat", ent(base + 3).dat, 32'd500);
        tick();
        tick();
        for (int i = 0; i < 400 && !(wb_stb_o && wb_adr_o == A_TAG); i++)
            tick();
        check("rdtag_pending", 32'(wb_stb_o && wb_adr_o == A_TAG), 32'd1);
        check("valid_pre_rst", 32'(tag_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("arst_valid", 32'(tag_valid), 32'd0);
        tick();
        tick();
        check("arst_busy", 32'(busy), 32'd0);
        s_delay = 0;
        base = log_q.size();
        rst_n = 1'b1;
        wait_log(base + 2, 100, "rearm_seen");
        check("rearm_arm", {13'd0, ent(base).adr, ent(base).we},
              {13'd0, A_CTRL, 1'b1});
        check("rearm_arm_dat", ent(base).dat, 32'h1);
        check("rearm_load", 32'(ent(base + 1).adr), 32'(A_INIT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wrc_tag_poller.md
Name: wrc_tag_poller

Overview:
- Wishbone master that sequences the WR core's tag-capture register block (CTRL/TAG/INIT) without software involvement.
- Arms the tagger, loads the initial value, and periodically polls the CTRL status bit.
- Reads each captured tag and buffers it in a small FIFO with a valid/ready output.
- Sits between the system-side fabric and the wr_core slave port, in the clk_sys domain.

Parameters:
- g_base_addr, 18'h40000, byte base address of the tag block. CTRL=+0x0, TAG=+0x4, INIT=+0x10.
- g_init_value, 32'h0000dead, value written to INIT during arming.
- g_poll_interval, 100, clk_sys cycles from WAIT entry to the next CTRL poll (>=1).
- g_ack_timeout, 64, cycles without wb_ack_i before a bus cycle is aborted.
- g_fifo_depth_log2, 3, tag FIFO depth = 2**g_fifo_depth_log2.

Ports:
- clk_sys_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- enable_i  in  1  level; 1=arm and poll, 0=disarm
- tag_o  out  32  FIFO head tag
- tag_valid_o  out  1  tag_o valid
- tag_ready_i  in  1  consumer accepts head when tag_valid_o=1
- overflow_o  out  1  sticky: a poll was skipped because the FIFO was full
- bus_err_o  out  1  sticky: ack timeout occurred
- clr_i  in  1  clears overflow_o and bus_err_o
- busy_o  out  1  FSM not in IDLE
- wb_adr_o  out  18  byte address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  constant 4'b1111
- wb_we_o  out  1  write enable
- wb_cyc_o, wb_stb_o  out  1  classic Wishbone cycle/strobe
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- Reset: all outputs are 0 except wb_sel_o=4'hF. FIFO is empty, FSM is in IDLE, counters are 0. Reset mid-cycle drops cyc/stb immediately. No recovery transaction is issued.
- Bus rules (classic, single outstanding):
  - cyc/stb/adr/we/dat are registered and held stable until wb_ack_i.
  - cyc/stb drop on the edge after ack. They stay low for at least 1 cycle between transactions.
  - Read data is captured on the ack cycle.
- FSM states:
  - IDLE: when enable_i=1, go to ARM.
  - ARM: write 32'h1 to CTRL. On ack, go to LOAD.
  - LOAD: write g_init_value to INIT. On ack, go to WAIT (counter cleared).
  - WAIT: count up. When count==g_poll_interval-1 and the FIFO is not full, go to POLL. If the FIFO is full at that point, set overflow_o and restart the count.
  - POLL: read CTRL. On ack, if rdata[3]=1 go to RDTAG, else go to WAIT.
  - RDTAG: read TAG. On ack, push rdata into the FIFO and go to WAIT.
  - DISARM: write 32'h0 to CTRL. On ack, go to IDLE.
- Disable handling:
  - enable_i=0 is sampled only in WAIT, or at the ack of any transaction.
  - An in-flight transaction always completes; the FSM then goes to DISARM.
  - A tag read in RDTAG is still pushed.
- Timeout:
  - The ack-wait counter restarts at each stb assertion.
  - On reaching g_ack_timeout with no ack: drop cyc/stb, set bus_err_o, go to WAIT (or DISARM if enable_i=0). No FIFO push.
- FIFO:
  - Push occurs on the ack cycle. tag_valid_o/tag_o update on the next edge.
  - Pop occurs when tag_valid_o & tag_ready_i.
  - Simultaneous push+pop is allowed at any fill level, including full (pop frees the slot). Count is unchanged.
  - Pointers wrap modulo depth. The count is g_fifo_depth_log2+1 bits.
- clr_i has priority over a same-cycle set of the sticky flags (the flag is cleared).
- busy_o = (state != IDLE).

Test Plan:
- Reset then enable_i=1 -> writes 0x40000<=1 then 0x40010<=0xdead; first CTRL read stb asserts 100 cycles after LOAD ack.
- Slave returns CTRL=0x8 then TAG=42 -> tag_o=42, tag_valid_o=1 the cycle after TAG ack; tag_ready_i=1 pops it, tag_valid_o=0 next cycle.
- tag_ready_i=0, 9 consecutive tags with depth 8 -> 8 buffered, overflow_o=1, no TAG read while full; one pop plus same-cycle push keeps count=8.
- Slave never acks the POLL -> cyc/stb drop after 64 cycles, bus_err_o=1, polling resumes; clr_i=1 -> bus_err_o=0.
- enable_i=0 during a pending POLL (ack delayed 5 cycles) -> POLL completes, then CTRL<=0 write, then IDLE with busy_o=0.
- rst_n_i low mid-RDTAG -> cyc/stb/tag_valid_o are 0 immediately (asynchronous); after release, the ARM sequence restarts if enable_i=1.
